// File: rtl/fb_pkg.sv
// Shared constants and swap-state encoding for the ping-pong frame store.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fb_pkg;

    localparam int FB_DATA_W = 16;     // pixel width
    localparam int FB_ADDR_W = 15;     // pixel address width per bank
    localparam int FB_DEPTH  = 19200;  // 160x120 pixels per bank
    localparam int FB_NUM_RD = 2;      // scan-out ports

    // Swap controller state: PENDING means a finished frame sits in the back bank.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_st_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Latency: 1 cycle from re/raddr to rdata; rdata holds while re is low.
// Backpressure: none, accepts one write and one read every cycle.
//
// Ports: clk; we/waddr/wdata write side; re/raddr read side; rdata registered data.
module fb_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    // No reset on the storage or the output register so this maps onto block RAM;
    // the top level forces the visible read data to zero out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fb_pingpong.sv
// Double-buffered multi-reader frame store; banks swap only at vsync after a finished frame.
// Latency: 1 cycle read (rd_en -> rd_valid/rd_data); writes visible after the next swap.
// Backpressure: none, one write plus NUM_RD reads accepted every cycle.
//
// Ports: clk, resetn (async active-low); wr_en/wr_addr/wr_data/wr_frame_done writer side;
// rd_frame_start vsync; rd_en/rd_addr/rd_data/rd_valid packed per-port readers;
// front_sel, swap_pending, dropped_frames status.
module fb_pingpong
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int NUM_RD = FB_NUM_RD
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_frame_done,
    input  logic                     rd_frame_start,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     front_sel,
    output logic                     swap_pending,
    output logic [7:0]               dropped_frames
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    swap_st_t state, state_nxt;
    logic     pend_nxt;
    logic     do_swap;
    logic     do_drop;

    // ---------------- swap controller ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        pend_nxt  = (state == ST_PENDING) | wr_frame_done;
        // A done pulse arriving with vsync from IDLE swaps in the same cycle.
        if (rd_frame_start && pend_nxt) begin
            do_swap   = 1'b1;
            state_nxt = ST_IDLE;
        end else if (pend_nxt) begin
            state_nxt = ST_PENDING;
        end
    end

    // A second finished frame overwrote one that was never shown.
    assign do_drop      = wr_frame_done && (state == ST_PENDING);
    assign swap_pending = (state == ST_PENDING);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            front_sel      <= 1'b0;
            dropped_frames <= 8'd0;
        end else begin
            if (do_swap) begin
                front_sel <= ~front_sel;
            end
            if (do_drop && dropped_frames != 8'hFF) begin
                dropped_frames <= dropped_frames + 8'd1;
            end
        end
    end

    // ---------------- write side ----------------
    logic wr_ok;
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);

    // ---------------- replicated read ports ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] ram_q;
        logic              zero_q;

        assign raddr = rd_addr[i*ADDR_W +: ADDR_W];

        fb_ram #(
            .DATA_W (DATA_W),
            .AW     (ADDR_W + 1)
        ) u_ram (
            .clk   (clk),
            .we    (wr_ok),
            .waddr ({~front_sel, wr_addr}),
            .wdata (wr_data),
            .re    (rd_en[i]),
            .raddr ({front_sel, raddr}),
            .rdata (ram_q)
        );

        // zero_q masks the RAM output: set for out-of-range reads and out of reset,
        // and only updated on a read so held data stays consistent with ram_q.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                zero_q <= 1'b1;
            end else if (rd_en[i]) begin
                zero_q <= ({1'b0, raddr} >= DEPTH_L);
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = zero_q ? '0 : ram_q;
    end

endmodule

// File: tb/tb_fb_pingpong.sv
// Self-checking bench for fb_pingpong: directed stimulus, per-port read scoreboard.
// Latency: reads expected one cycle after issue.
// Backpressure: none exercised (the design has none).
module tb_fb_pingpong;

    localparam int DW = 16;
    localparam int AW = 15;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             wr_frame_done = 1'b0;
    logic             rd_frame_start = 1'b0;
    logic [NR-1:0]    rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_valid;
    logic             front_sel;
    logic             swap_pending;
    logic [7:0]       dropped_frames;

    fb_pingpong #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (19200),
        .NUM_RD (NR)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .front_sel      (front_sel),
        .swap_pending   (swap_pending),
        .dropped_frames (dropped_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            ne;   // expect anything except d
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            if (rd_valid[p]) begin
                exp_t          e;
                logic [DW-1:0] act;
                int            qs;
                act = rd_data[p*DW +: DW];
                qs  = (p == 0) ? q0.size() : q1.size();
                checks++;
                if (qs == 0) begin
                    errors++;
                    $display("FAIL rd%0d_unexpected_valid got=%h with nothing outstanding", p, act);
                end else begin
                    if (p == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (e.ne && act == e.d) begin
                        errors++;
                        $display("FAIL rd%0d_stale got=%h must differ from %h", p, act, e.d);
                    end else if (!e.ne && act !== e.d) begin
                        errors++;
                        $display("FAIL rd%0d_data got=%h expected=%h", p, act, e.d);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
    endtask

    task automatic pulse_vsync();
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
    endtask

    task automatic issue_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ne);
        exp_t e;
        e.d  = d;
        e.ne = ne;
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic end_rd();
        tick();
        rd_en = '0;
        tick();   // let the monitor consume the response
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 resetn = 1'b0;
        tick(); tick();
        check("rst_front_sel", {31'd0, front_sel}, 32'd0);
        check("rst_swap_pending", {31'd0, swap_pending}, 32'd0);
        check("rst_dropped", {24'd0, dropped_frames}, 32'd0);
        check("rst_rd_valid", {30'd0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        resetn = 1'b1;
        tick();

        // Reset and swap: write lands in bank 1, front stays bank 0.
        write_px(15'd5, 16'h1234);
        pulse_done();
        check("pend_after_done", {31'd0, swap_pending}, 32'd1);
        issue_rd(0, 15'd5, 16'h1234, 1'b1);
        end_rd();
        // Read issued in the swap cycle still uses the old bank.
        rd_frame_start = 1'b1;
        issue_rd(1, 15'd5, 16'h1234, 1'b1);
        tick();
        rd_frame_start = 1'b0;
        rd_en = '0;
        check("swap_front_sel", {31'd0, front_sel}, 32'd1);
        check("swap_clears_pend", {31'd0, swap_pending}, 32'd0);
        tick();
        issue_rd(0, 15'd5, 16'h1234, 1'b0);
        end_rd();

        // No early swap.
        pulse_vsync();
        check("noswap_front_sel", {31'd0, front_sel}, 32'd1);
        check("noswap_pending", {31'd0, swap_pending}, 32'd0);

        // Simultaneous done + vsync from IDLE.
        wr_frame_done  = 1'b1;
        rd_frame_start = 1'b1;
        tick();
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
        check("simul_front_sel", {31'd0, front_sel}, 32'd0);
        check("simul_pending", {31'd0, swap_pending}, 32'd0);
        check("simul_dropped", {24'd0, dropped_frames}, 32'd0);

        // Out-of-range write and dual read (back bank is 1 now).
        write_px(15'd0, 16'h0A0A);
        write_px(15'd7, 16'h0707);
        write_px(15'd19200, 16'hDEAD);
        pulse_done();
        pulse_vsync();
        check("dual_front_sel", {31'd0, front_sel}, 32'd1);
        issue_rd(0, 15'd0, 16'h0A0A, 1'b0);
        issue_rd(1, 15'd7, 16'h0707, 1'b0);
        end_rd();
        issue_rd(1, 15'd19200, 16'h0000, 1'b0);
        end_rd();
        // Data hold on port 0 with rd_valid low.
        check("hold_rd0_data", {16'd0, rd_data[15:0]}, 32'h0A0A);
        check("hold_rd_valid", {30'd0, rd_valid}, 32'd0);
        // A back-bank write must not disturb the front bank.
        write_px(15'd7, 16'h7777);
        issue_rd(1, 15'd7, 16'h0707, 1'b0);
        end_rd();

        // Drop counting.
        pulse_done();
        pulse_done();
        pulse_done();
        check("drop3_count", {24'd0, dropped_frames}, 32'd2);
        check("drop3_pending", {31'd0, swap_pending}, 32'd1);
        // Drop still counted when vsync coincides; the swap happens.
        wr_frame_done  = 1'b1;
        rd_frame_start = 1'b1;
        tick();
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
        check("drop_swap_count", {24'd0, dropped_frames}, 32'd3);
        check("drop_swap_front", {31'd0, front_sel}, 32'd0);
        check("drop_swap_pending", {31'd0, swap_pending}, 32'd0);
        // The newest frame (0x7777 at address 7) is now visible.
        issue_rd(0, 15'd7, 16'h7777, 1'b0);
        end_rd();

        for (int i = 0; i < 300; i++) pulse_done();
        check("drop_saturate", {24'd0, dropped_frames}, 32'd255);
        check("sat_pending", {31'd0, swap_pending}, 32'd1);
        pulse_vsync();
        check("sat_swap_front", {31'd0, front_sel}, 32'd1);
        pulse_done();

        // Asynchronous reset while PENDING.
        resetn = 1'b0;
        #1;
        check("arst_pending", {31'd0, swap_pending}, 32'd0);
        check("arst_front_sel", {31'd0, front_sel}, 32'd0);
        check("arst_dropped", {24'd0, dropped_frames}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) tick();
        check("sb_drain", q0.size() + q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
